// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a four-state debounce FSM with registered outputs.
// Define DEBOUNCER_FALL_EN to build the registered fall pulse; otherwise fall is tied to 0.
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > (2 ** CNT_WIDTH) - 1) begin : g_bad_cfg
        $error("input_debouncer: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        StLow,
        StWaitHigh,
        StHigh,
        StWaitLow
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sync0_q, sync1_q;
    logic                 dout_q, dout_d;
    logic                 rise_q, busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StLow: begin
                if (sync1_q) begin
                    state_d = StWaitHigh;
                    cnt_d   = CNT_WIDTH'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            StWaitHigh: begin
                if (!sync1_q) begin
                    state_d = StLow;
                    cnt_d   = '0;
                end else if (cnt_q >= CntMax) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHigh: begin
                if (!sync1_q) begin
                    state_d = StWaitLow;
                    cnt_d   = CNT_WIDTH'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            StWaitLow: begin
                if (sync1_q) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else if (cnt_q >= CntMax) begin
                    state_d = StLow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StLow;
                cnt_d   = '0;
            end
        endcase
        // Outputs are decoded from the next state so they register on the transition edge.
        dout_d = (state_d == StHigh) || (state_d == StWaitLow);
        busy_d = (state_d == StWaitHigh) || (state_d == StWaitLow);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            state_q <= StLow;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync0_q <= din;
            sync1_q <= sync0_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= dout_d & ~dout_q;
            busy_q  <= busy_d;
        end
    end

`ifdef DEBOUNCER_FALL_EN
    logic fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= dout_q & ~dout_d;
        end
    end

    assign fall = fall_q;
`else
    assign fall = 1'b0;
`endif

    assign dout = dout_q;
    assign rise = rise_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (DEBOUNCE_CYCLES=4): vector table + scoreboard queue,
// plus hand-written reset-priority and latency sequences.
module tb_input_debouncer;

    logic clk;
    logic reset;
    logic din;
    logic dout;
    logic rise;
    logic fall;
    logic busy;
    logic ff_q;

    int total = 0;
    int bad   = 0;

`ifdef DEBOUNCER_FALL_EN
    localparam logic FE = 1'b1;
`else
    localparam logic FE = 1'b0;
`endif

    typedef struct {
        logic rst;
        logic din;
        logic dout;
        logic rise;
        logic fall;
        logic busy;
        logic ffq;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    input_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    // Downstream flip-flop fed by dout.
    always_ff @(posedge clk) begin
        if (reset) ff_q <= 1'b0;
        else       ff_q <= dout;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic d, input logic o, input logic ri,
                       input logic fa, input logic bu, input logic fq);
        vec_t v;
        v.rst = r; v.din = d; v.dout = o; v.rise = ri; v.fall = fa; v.busy = bu; v.ffq = fq;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic d);
        @(negedge clk);
        reset = r;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        exp_q.push_back(v);
        step(v.rst, v.din);
        e = exp_q.pop_front();
        check("dout", idx, dout, e.dout);
        check("rise", idx, rise, e.rise);
        check("fall", idx, fall, e.fall);
        check("busy", idx, busy, e.busy);
        check("ffq", idx, ff_q, e.ffq);
    endtask

    initial begin
        int n;
        bit seen;
        reset = 1'b1;
        din   = 1'b0;

        // Reset two cycles with din=1, then release: dout/rise at the 6th edge after release.
        add(1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 0, (i >= 2), 0);
        add(0, 1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 1);
        // Falling qualification from dout=1.
        for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 0, (i >= 2), 1);
        add(0, 0, 0, 0, FE, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // Three-cycle pulse is rejected.
        for (int i = 0; i < 8; i++) add(0, (i < 3), 0, 0, 0, (i >= 2 && i <= 4), 0);
        // Toggle every 2 cycles for 12 cycles, then hold 1.
        for (int i = 0; i < 12; i++) add(0, ((i % 4) < 2), 0, 0, 0, ((i % 4) >= 2), 0);
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset in WAIT_HIGH with cnt=3.
        step(1, 0);
        for (int i = 0; i < 5; i++) step(0, 1);
        check("cnt_before_reset", 100, (dut.cnt_q == 4'd3), 1'b1);
        check("busy_before_reset", 100, busy, 1'b1);
        step(1, 1);
        check("cnt_after_reset", 101, (dut.cnt_q == 4'd0), 1'b1);
        check("busy_after_reset", 101, busy, 1'b0);
        check("rise_after_reset", 101, rise, 1'b0);
        check("dout_after_reset", 101, dout, 1'b0);

        // Reset wins over a qualification completing on the same edge.
        for (int i = 0; i < 6; i++) step(0, 1);
        check("cnt_full", 102, (dut.cnt_q == 4'd4), 1'b1);
        step(1, 1);
        check("dout_prio", 103, dout, 1'b0);
        check("rise_prio", 103, rise, 1'b0);
        check("busy_prio", 103, busy, 1'b0);

        // Latency after release with din held high, bounded wait.
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            step(0, 1);
            if (dout) seen = 1;
            else n++;
        end
        check("latency_seen", 104, seen, 1'b1);
        check("latency_is_6", 104, (n == 6), 1'b1);
        check("rise_latency", 104, rise, 1'b1);
        check("ffq_lag", 104, ff_q, 1'b0);
        step(0, 1);
        check("rise_single", 105, rise, 1'b0);
        check("ffq_follow", 105, ff_q, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronized samples required to accept a new level.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 4, meaning stability counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port din, input, 1 bit: raw asynchronous, possibly bouncing input.
REQ-006 The block SHALL have port dout, output, 1 bit: debounced level; it drives the D input of the downstream flip-flop stage.
REQ-007 The block SHALL have port rise, output, 1 bit: one-cycle pulse when dout goes 0->1.
REQ-008 The block SHALL have port fall, output, 1 bit: one-cycle pulse when dout goes 1->0 (see Configuration).
REQ-009 The block SHALL have port busy, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-010 din SHALL pass through a two-register synchronizer, sync0 then sync1, before any other use.
REQ-011 The FSM SHALL have exactly four states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
REQ-012 In LOW with sync1=1: next state WAIT_HIGH, cnt<=1; with sync1=0: stay, cnt<=0.
REQ-013 In WAIT_HIGH with sync1=1 and cnt<DEBOUNCE_CYCLES: cnt<=cnt+1; when cnt reaches DEBOUNCE_CYCLES: next state HIGH, cnt<=0.
REQ-014 In WAIT_HIGH with sync1=0: return to LOW, cnt<=0, no output change (glitch rejected).
REQ-015 HIGH and WAIT_LOW SHALL mirror REQ-012 to REQ-014 with polarities inverted.
REQ-016 dout SHALL be a registered output: 1 in HIGH and WAIT_LOW, 0 in LOW and WAIT_HIGH.
REQ-017 Latency: a din change stable from the setup time before edge k SHALL appear on dout at edge k+DEBOUNCE_CYCLES+2.
REQ-018 rise SHALL be registered, asserted for exactly one cycle on the same edge dout goes 0->1; never asserted for two consecutive cycles.
REQ-019 busy SHALL be 1 exactly in WAIT_HIGH and WAIT_LOW.
REQ-020 cnt SHALL never exceed DEBOUNCE_CYCLES; the legal range is 1 <= DEBOUNCE_CYCLES <= 2^CNT_WIDTH-1, and an out-of-range value SHALL stop elaboration with an error.
REQ-021 A pulse on din shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no dout, rise or fall activity.

Reset
REQ-022 With reset=1 at a rising clk edge: sync0, sync1, cnt, dout, rise, fall and busy SHALL be 0 and state SHALL be LOW, regardless of the current state.
REQ-023 Reset SHALL have no effect between clock edges.
REQ-024 Reset SHALL take priority over every FSM transition, including a qualification completing on the same edge.
REQ-025 After reset deasserts with din=1 held, dout SHALL rise per REQ-017, counting from the first edge with reset=0.

Configuration
REQ-026 Macro DEBOUNCER_FALL_EN SHALL control the fall output.
REQ-027 With DEBOUNCER_FALL_EN defined: fall SHALL be registered and pulse for one cycle on the edge dout goes 1->0.
REQ-028 Without DEBOUNCER_FALL_EN: the fall port SHALL still exist, SHALL be tied to constant 0, and no fall register SHALL be synthesized.

Verification (DEBOUNCE_CYCLES=4, clock period 10)
REQ-029 Reset for 2 cycles with din=1, then release -> dout, rise and busy are 0 during reset; dout=1 and rise=1 for one cycle at the 6th edge after release.
REQ-030 din=1 for 3 cycles, then 0 -> busy goes high then low; dout, rise and fall remain 0 throughout.
REQ-031 din toggles every 2 cycles for 12 cycles, then held at 1 -> dout=1 exactly 6 edges after din settles; a single rise pulse.
REQ-032 From dout=1, din=0 held -> dout=0 after 6 edges; fall pulses 1 cycle with DEBOUNCER_FALL_EN defined and stays 0 without it.
REQ-033 reset asserted in WAIT_HIGH with cnt=3 -> next edge: state LOW, cnt=0, busy=0, no rise pulse.
REQ-034 dout connected to the downstream flip-flop's D input with din=1 stable -> flip-flop Q=1 one edge after dout=1.
